// File: rtl/add16_accum_seq_if.sv
// Operand stream, external ripple-adder hookup and result handshake for add16_accum_seq.
interface add16_accum_seq_if #(
    parameter int CNT_W = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [15:0]      in_data;
    logic             in_sub;
    logic             in_clear;
    logic             in_last;

    logic [15:0]      add_a;
    logic [15:0]      add_b;
    logic             add_cin;
    logic [15:0]      add_sum;
    logic             add_cout;

    logic             out_valid;
    logic             out_ready;
    logic [15:0]      out_sum;
    logic             out_ovf;
    logic [CNT_W-1:0] out_count;

    modport slave (
        input  in_valid, in_data, in_sub, in_clear, in_last,
        input  add_sum, add_cout, out_ready,
        output in_ready, add_a, add_b, add_cin,
        output out_valid, out_sum, out_ovf, out_count
    );

    modport master (
        output in_valid, in_data, in_sub, in_clear, in_last,
        output add_sum, add_cout, out_ready,
        input  in_ready, add_a, add_b, add_cin,
        input  out_valid, out_sum, out_ovf, out_count
    );
endinterface

// File: rtl/add16_accum_seq.sv
// Sequencer around an external 16-bit ripple adder: holds operands for the settle
// time, accumulates sum/carry and hands the result over a valid/ready handshake.
//
//   state  | meaning
//   IDLE   | ready for an operand
//   SETTLE | adder inputs held while the ripple chain settles
//   DONE   | result presented, waiting for out_ready
module add16_accum_seq #(
    parameter int SETTLE_CYCLES = 2,
    parameter int CNT_W         = 8
) (
    input logic          clk,
    input logic          rst_n,
    add16_accum_seq_if.slave bus
);
    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] SETTLE = 2'd1;
    localparam logic [1:0] DONE   = 2'd2;

    localparam logic [3:0]       SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX     = '1;

    logic [1:0]       state;
    logic [15:0]      acc;
    logic [15:0]      op_reg;
    logic             sub_reg;
    logic             clr_reg;
    logic             last_reg;
    logic             ovf;
    logic [CNT_W-1:0] count;
    logic [3:0]       settle_cnt;

    logic             step_ovf;
    logic [CNT_W-1:0] count_next;

    // Adder is driven purely from registers so its inputs stay frozen during SETTLE.
    assign bus.add_a   = clr_reg ? 16'h0000 : acc;
    assign bus.add_b   = sub_reg ? ~op_reg : op_reg;
    assign bus.add_cin = sub_reg;

    assign bus.in_ready  = (state == IDLE);
    assign bus.out_valid = (state == DONE);
    assign bus.out_sum   = acc;
    assign bus.out_ovf   = ovf;
    assign bus.out_count = count;

    // In subtract mode a missing carry-out means a borrow occurred.
    assign step_ovf   = sub_reg ? ~bus.add_cout : bus.add_cout;
    assign count_next = clr_reg ? CNT_W'(1)
                      : ((count == CNT_MAX) ? count : count + CNT_W'(1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            acc        <= '0;
            op_reg     <= '0;
            sub_reg    <= 1'b0;
            clr_reg    <= 1'b0;
            last_reg   <= 1'b0;
            ovf        <= 1'b0;
            count      <= '0;
            settle_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        op_reg     <= bus.in_data;
                        sub_reg    <= bus.in_sub;
                        clr_reg    <= bus.in_clear;
                        last_reg   <= bus.in_last;
                        settle_cnt <= SETTLE_LOAD;
                        state      <= SETTLE;
                    end
                end
                SETTLE: begin
                    if (settle_cnt == 4'd0) begin
                        acc   <= bus.add_sum;
                        ovf   <= (clr_reg ? 1'b0 : ovf) | step_ovf;
                        count <= count_next;
                        state <= last_reg ? DONE : IDLE;
                    end else begin
                        settle_cnt <= settle_cnt - 4'd1;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        acc     <= '0;
                        ovf     <= 1'b0;
                        count   <= '0;
                        clr_reg <= 1'b0;
                        state   <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_add16_accum_seq.sv
// Randomized + directed bench for add16_accum_seq; two instances (CNT_W=8 and 2) share stimulus.
module tb_add16_accum_seq;
    localparam int S = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    add16_accum_seq_if #(.CNT_W(8)) bus8 ();
    add16_accum_seq_if #(.CNT_W(2)) bus2 ();

    // Behavioural stand-in for the ripple adder.
    assign {bus8.add_cout, bus8.add_sum} = {1'b0, bus8.add_a} + {1'b0, bus8.add_b} + {16'h0000, bus8.add_cin};
    assign {bus2.add_cout, bus2.add_sum} = {1'b0, bus2.add_a} + {1'b0, bus2.add_b} + {16'h0000, bus2.add_cin};

    add16_accum_seq #(.SETTLE_CYCLES(S), .CNT_W(8)) dut8 (.clk(clk), .rst_n(rst_n), .bus(bus8));
    add16_accum_seq #(.SETTLE_CYCLES(S), .CNT_W(2)) dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2));

    int n_cmp = 0;
    int n_err = 0;

    logic [15:0] macc;
    bit          movf;
    int          mcnt8, mcnt2;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit v, input logic [15:0] d, input bit s, input bit c, input bit l);
        bus8.in_valid = v; bus8.in_data = d; bus8.in_sub = s; bus8.in_clear = c; bus8.in_last = l;
        bus2.in_valid = v; bus2.in_data = d; bus2.in_sub = s; bus2.in_clear = c; bus2.in_last = l;
    endtask

    task automatic set_oready(input bit r);
        bus8.out_ready = r;
        bus2.out_ready = r;
    endtask

    task automatic model_clear();
        macc = 16'h0000; movf = 1'b0; mcnt8 = 0; mcnt2 = 0;
    endtask

    task automatic check_reset_outs(input string tag);
        chk({tag, ".in_ready"},  bus8.in_ready,  1);
        chk({tag, ".out_valid"}, bus8.out_valid, 0);
        chk({tag, ".add_a"},     bus8.add_a,     0);
        chk({tag, ".add_b"},     bus8.add_b,     0);
        chk({tag, ".add_cin"},   bus8.add_cin,   0);
        chk({tag, ".out_sum"},   bus8.out_sum,   0);
        chk({tag, ".out_ovf"},   bus8.out_ovf,   0);
        chk({tag, ".out_count"}, bus8.out_count, 0);
        chk({tag, ".count2"},    bus2.out_count, 0);
    endtask

    // Present one operand, wait for acceptance, then check the settle window and what follows it.
    task automatic send(input logic [15:0] d, input bit s, input bit c, input bit l);
        logic [15:0] ea, eb;
        bit ok, step;
        ok = 1'b0;
        drive(1'b1, d, s, c, l);
        for (int w = 0; w < 40; w++) begin
            if (bus8.in_ready) begin
                ok = 1'b1;
                tick();
                break;
            end
            tick();
        end
        if (!ok) begin
            chk("accept_timeout", 0, 1);
            drive(1'b0, 16'h0, 1'b0, 1'b0, 1'b0);
            return;
        end
        ea = c ? 16'h0000 : macc;
        eb = s ? ~d : d;
        if (c) model_clear();
        if (s) begin
            step = (macc < d);
            macc = macc - d;
        end else begin
            step = ((int'(macc) + int'(d)) > 65535);
            macc = macc + d;
        end
        movf  = movf | step;
        mcnt8 = (mcnt8 < 255) ? mcnt8 + 1 : 255;
        mcnt2 = (mcnt2 < 3) ? mcnt2 + 1 : 3;
        // Operand stays presented during SETTLE; it must not be taken again.
        for (int k = 0; k < S; k++) begin
            chk("settle.in_ready",  bus8.in_ready,  0);
            chk("settle.out_valid", bus8.out_valid, 0);
            chk("settle.add_a",     bus8.add_a,     ea);
            chk("settle.add_b",     bus8.add_b,     eb);
            chk("settle.add_cin",   bus8.add_cin,   s);
            tick();
        end
        drive(1'b0, 16'h0, 1'b0, 1'b0, 1'b0);
        chk("post.in_ready",  bus8.in_ready,  !l);
        chk("post.out_valid", bus8.out_valid, l);
    endtask

    // Hold off the result for 'hold' cycles, then accept it.
    task automatic recv(input int hold);
        set_oready(1'b0);
        for (int k = 0; k < hold; k++) begin
            drive(1'b1, 16'(32'($urandom)), 1'b0, 1'b1, 1'b1);
            chk("bp.out_valid", bus8.out_valid, 1);
            chk("bp.in_ready",  bus8.in_ready,  0);
            chk("bp.out_sum",   bus8.out_sum,   macc);
            tick();
        end
        drive(1'b0, 16'h0, 1'b0, 1'b0, 1'b0);
        chk("res.out_valid", bus8.out_valid, 1);
        chk("res.out_sum",   bus8.out_sum,   macc);
        chk("res.out_ovf",   bus8.out_ovf,   movf);
        chk("res.count8",    bus8.out_count, mcnt8);
        chk("res.sum2",      bus2.out_sum,   macc);
        chk("res.count2",    bus2.out_count, mcnt2);
        set_oready(1'b1);
        tick();
        set_oready(1'b0);
        chk("acc.out_valid", bus8.out_valid, 0);
        chk("acc.in_ready",  bus8.in_ready,  1);
        model_clear();
    endtask

    initial begin
        int n;
        logic [15:0] d;
        bit s, c;

        drive(1'b0, 16'h0, 1'b0, 1'b0, 1'b0);
        set_oready(1'b0);
        model_clear();
        #12;
        check_reset_outs("rst");
        @(negedge clk) rst_n = 1'b1;
        tick();
        chk("rst.release_ready", bus8.in_ready, 1);

        send(16'h1234, 1'b0, 1'b1, 1'b0);
        send(16'h1111, 1'b0, 1'b0, 1'b0);
        send(16'h0001, 1'b0, 1'b0, 1'b1);
        chk("t2.sum",   bus8.out_sum,   16'h2346);
        chk("t2.ovf",   bus8.out_ovf,   0);
        chk("t2.count", bus8.out_count, 3);
        recv(0);

        send(16'hFFFF, 1'b0, 1'b1, 1'b0);
        send(16'h0001, 1'b0, 1'b0, 1'b1);
        chk("t3.sum", bus8.out_sum, 16'h0000);
        chk("t3.ovf", bus8.out_ovf, 1);
        recv(0);
        send(16'h0005, 1'b0, 1'b1, 1'b1);
        chk("t3b.ovf",   bus8.out_ovf,   0);
        chk("t3b.count", bus8.out_count, 1);
        recv(0);

        send(16'h0010, 1'b0, 1'b1, 1'b0);
        send(16'h0011, 1'b1, 1'b0, 1'b1);
        chk("t4.sum", bus8.out_sum, 16'hFFFF);
        chk("t4.ovf", bus8.out_ovf, 1);
        recv(0);

        send(16'h0007, 1'b0, 1'b1, 1'b1);
        recv(10);

        for (int i = 0; i < 6; i++) send(16'h4000 + 16'(i), 1'b0, (i == 0), (i == 5));
        chk("t6.count2", bus2.out_count, 3);
        chk("t6.count8", bus8.out_count, 6);
        chk("t6.sum2",   bus2.out_sum,   16'h800F);
        recv(2);

        // Mid-sequence clear restarts sum, flag and count.
        send(16'hFFFF, 1'b0, 1'b1, 1'b0);
        send(16'h0002, 1'b0, 1'b0, 1'b0);
        send(16'h0003, 1'b0, 1'b1, 1'b1);
        chk("clr.sum",   bus8.out_sum,   16'h0003);
        chk("clr.ovf",   bus8.out_ovf,   0);
        chk("clr.count", bus8.out_count, 1);
        recv(1);

        drive(1'b1, 16'hABCD, 1'b0, 1'b1, 1'b0);
        tick();
        drive(1'b0, 16'h0, 1'b0, 1'b0, 1'b0);
        chk("rstmid.in_settle", bus8.in_ready, 0);
        rst_n = 1'b0;
        #1;
        check_reset_outs("rstmid");
        model_clear();
        @(negedge clk) rst_n = 1'b1;
        tick();
        chk("rstmid.release_ready", bus8.in_ready, 1);

        send(16'h0042, 1'b0, 1'b1, 1'b1);
        #1 rst_n = 1'b0;
        #1;
        check_reset_outs("rstdone");
        model_clear();
        @(negedge clk) rst_n = 1'b1;
        tick();

        for (int seq = 0; seq < 40; seq++) begin
            n = $urandom_range(1, 7);
            for (int j = 0; j < n; j++) begin
                case ($urandom_range(0, 3))
                    0: d = 16'hFFFF;
                    1: d = 16'h0001;
                    default: d = 16'(32'($urandom));
                endcase
                s = 1'($urandom_range(0, 1));
                c = (j == 0) ? 1'($urandom_range(0, 1)) : ($urandom_range(0, 7) == 0);
                set_oready(1'($urandom_range(0, 1)));
                send(d, s, c, (j == n - 1));
            end
            recv($urandom_range(0, 3));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
